tile_blitter: RTL and testbench

//  Command-driven controller that copies one 32x32 tile from the background/character/wall

---
 rtl/tile_blitter.sv | 175 +++++++++++++++++
 tb/tb_tile_blitter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_blitter.sv
// ---------------------------------------------------------------------------
// tile_blitter
//   Copies one TILE x TILE block from the background, character or wall ROM,
//   or a solid fill colour, into the VRAM write port. Owns VRAM port A, but a
//   direct CPU pixel write always takes the port. While the CPU writes, the
//   blit pauses.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_tile/x/y/transp/color       command fields, latched on accept
//   rom_addr                        shared ROM address {py,px}
//   bg_data/chr_data/wall_data      asynchronous ROM read data
//   cpu_vram_we/addr/data           CPU direct VRAM write
//   vram_we/addr/data               registered VRAM write port
//   busy, done                      status (done is a one-cycle pulse)
// ---------------------------------------------------------------------------
module tile_blitter #(
    parameter int          SCREEN_W  = 640,
    parameter int          SCREEN_H  = 480,
    parameter int          TILE      = 32,
    parameter logic [11:0] KEY_COLOR = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_tile,
    input  logic [9:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic        cmd_transp,
    input  logic [11:0] cmd_color,
    output logic [9:0]  rom_addr,
    input  logic [11:0] bg_data,
    input  logic [11:0] chr_data,
    input  logic [11:0] wall_data,
    input  logic        cpu_vram_we,
    input  logic [18:0] cpu_vram_addr,
    input  logic [11:0] cpu_vram_data,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_data,
    output logic        busy,
    output logic        done
);

    localparam int CW = $clog2(TILE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    state_t         w_next;

    logic [CW-1:0]  r_px;
    logic [CW-1:0]  r_py;
    logic [1:0]     r_tile;
    logic [9:0]     r_x;
    logic [8:0]     r_y;
    logic           r_transp;
    logic [11:0]    r_color;

    logic           r_vram_we;
    logic [18:0]    r_vram_addr;
    logic [11:0]    r_vram_data;

    logic           w_accept;
    logic           w_adv;
    logic           w_last;
    logic           w_clip;
    logic           w_key;
    logic           w_write;
    logic [11:0]    w_src;
    logic [10:0]    w_sx;
    logic [9:0]     w_sy;
    logic [18:0]    w_addr;

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign w_accept  = cmd_valid && cmd_ready;

    // A CPU write steals the cycle, so the pixel counters only move when the
    // port is free.
    assign w_adv  = (r_state == S_RUN) && !cpu_vram_we;
    assign w_last = (r_px == CW'(TILE - 1)) && (r_py == CW'(TILE - 1));

    assign rom_addr = 10'({r_py, r_px});

    always_comb begin
        case (r_tile)
            2'd0:    w_src = bg_data;
            2'd1:    w_src = chr_data;
            2'd2:    w_src = wall_data;
            default: w_src = r_color;
        endcase
    end

    // Screen coordinates are widened so that tiles hanging off the right or
    // bottom edge are clipped rather than wrapped.
    assign w_sx    = {1'b0, r_x} + 11'(r_px);
    assign w_sy    = {1'b0, r_y} + 10'(r_py);
    assign w_addr  = 19'(w_sy) * 19'(SCREEN_W) + 19'(w_sx);
    assign w_clip  = (w_sx >= 11'(SCREEN_W)) || (w_sy >= 10'(SCREEN_H));
    assign w_key   = r_transp && (r_tile != 2'd3) && (w_src == KEY_COLOR);
    assign w_write = (r_state == S_RUN) && !w_clip && !w_key;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_adv && w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px     <= '0;
            r_py     <= '0;
            r_tile   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_transp <= 1'b0;
            r_color  <= '0;
        end else if (w_accept) begin
            r_px     <= '0;
            r_py     <= '0;
            r_tile   <= cmd_tile;
            r_x      <= cmd_x;
            r_y      <= cmd_y;
            r_transp <= cmd_transp;
            r_color  <= cmd_color;
        end else if (w_adv) begin
            // px wraps naturally because TILE is a power of two
            r_px <= r_px + 1'b1;
            if (r_px == CW'(TILE - 1)) begin
                r_py <= r_py + 1'b1;
            end
        end
    end

    // VRAM write register: CPU first, then the blitter pixel; addr/data hold
    // when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vram_we   <= 1'b0;
            r_vram_addr <= '0;
            r_vram_data <= '0;
        end else if (cpu_vram_we) begin
            r_vram_we   <= 1'b1;
            r_vram_addr <= cpu_vram_addr;
            r_vram_data <= cpu_vram_data;
        end else if (w_write) begin
            r_vram_we   <= 1'b1;
            r_vram_addr <= w_addr;
            r_vram_data <= w_src;
        end else begin
            r_vram_we   <= 1'b0;
        end
    end

    assign vram_we   = r_vram_we;
    assign vram_addr = r_vram_addr;
    assign vram_data = r_vram_data;

endmodule

// File: tb/tb_tile_blitter.sv
module tb_tile_blitter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_tile;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic        cmd_transp;
    logic [11:0] cmd_color;
    logic [9:0]  rom_addr;
    logic [11:0] bg_data;
    logic [11:0] chr_data;
    logic [11:0] wall_data;
    logic        cpu_vram_we;
    logic [18:0] cpu_vram_addr;
    logic [11:0] cpu_vram_data;
    logic        vram_we;
    logic [18:0] vram_addr;
    logic [11:0] vram_data;
    logic        busy;
    logic        done;

    tile_blitter dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_tile     (cmd_tile),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_transp   (cmd_transp),
        .cmd_color    (cmd_color),
        .rom_addr     (rom_addr),
        .bg_data      (bg_data),
        .chr_data     (chr_data),
        .wall_data    (wall_data),
        .cpu_vram_we  (cpu_vram_we),
        .cpu_vram_addr(cpu_vram_addr),
        .cpu_vram_data(cpu_vram_data),
        .vram_we      (vram_we),
        .vram_addr    (vram_addr),
        .vram_data    (vram_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // ROM contents: distinct top bits per ROM; the wall ROM holds exactly 100
    // key-colour words (a*7 mod 1024 is a permutation of the address space).
    function automatic logic [11:0] rom_val(input logic [1:0] t, input logic [9:0] a);
        logic [9:0] h;
        h = a * 10'd7;
        case (t)
            2'd0:    return {2'b10, a};
            2'd1:    return {2'b01, a};
            2'd2:    return (h < 10'd100) ? 12'hF0F : {2'b00, a};
            default: return 12'h000;
        endcase
    endfunction

    assign bg_data   = rom_val(2'd0, rom_addr);
    assign chr_data  = rom_val(2'd1, rom_addr);
    assign wall_data = rom_val(2'd2, rom_addr);

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          stall_exp = 0;
    int          blit_wr = 0;
    bit          expect_done = 0;
    bit          done_seen = 0;
    bit          last_cpu = 0;
    logic [30:0] blit_q[$];
    logic [30:0] cpu_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard, sampling mid-cycle
    always @(negedge clk) begin
        logic [30:0] e;
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (last_cpu) begin
            chk("cpu_we", {31'd0, vram_we}, 32'd1);
            if (cpu_q.size() == 0) chk("cpu_q_empty", 32'd1, 32'd0);
            else begin
                e = cpu_q.pop_front();
                chk("cpu_addr", 32'(vram_addr), 32'(e[30:12]));
                chk("cpu_data", 32'(vram_data), 32'(e[11:0]));
            end
        end else if (vram_we) begin
            blit_wr++;
            if (blit_q.size() == 0) chk("blit_extra", 32'd1, 32'd0);
            else begin
                e = blit_q.pop_front();
                chk("blit_addr", 32'(vram_addr), 32'(e[30:12]));
                chk("blit_data", 32'(vram_data), 32'(e[11:0]));
            end
        end
        if (done) begin
            if (expect_done) begin
                chk("done_cyc", cyc, acc_cyc + 1025 + stall_exp);
                chk("done_busy", {31'd0, busy}, 32'd1);
                chk("done_ready", {31'd0, cmd_ready}, 32'd0);
                expect_done = 0;
                done_seen = 1;
            end else begin
                chk("spurious_done", 32'd1, 32'd0);
            end
        end
        if (cpu_vram_we) cpu_q.push_back({cpu_vram_addr, cpu_vram_data});
        last_cpu = cpu_vram_we;
    end

    task automatic issue(input logic [1:0] t, input int x, input int y,
                         input logic tr, input logic [11:0] col);
        int sx, sy;
        logic [11:0] src;
        for (int py = 0; py < 32; py++) begin
            for (int px = 0; px < 32; px++) begin
                sx = x + px;
                sy = y + py;
                src = (t == 2'd3) ? col : rom_val(t, 10'(py * 32 + px));
                if (sx < 640 && sy < 480 && !(tr && t != 2'd3 && src == 12'hF0F))
                    blit_q.push_back({19'(sy * 640 + sx), src});
            end
        end
        blit_wr     = 0;
        stall_exp   = 0;
        done_seen   = 0;
        expect_done = 1;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        cmd_tile   = t;
        cmd_x      = 10'(x);
        cmd_y      = 9'(y);
        cmd_transp = tr;
        cmd_color  = col;
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int nwr);
        int i;
        i = 0;
        while (!done_seen && i < 1200) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done_seen"}, {31'd0, done_seen}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_ready_back"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_q_left"}, blit_q.size(), 32'd0);
        chk({tag, "_writes"}, blit_wr, nwr);
        blit_q.delete();
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_tile = '0; cmd_x = '0; cmd_y = '0;
        cmd_transp = 1'b0; cmd_color = '0;
        cpu_vram_we = 1'b0; cpu_vram_addr = '0; cpu_vram_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", {31'd0, vram_we}, 32'd0);
        chk("rst_addr", 32'(vram_addr), 32'd0);
        chk("rst_data", 32'(vram_data), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: character tile at origin; a stray command mid-run must be ignored
        issue(2'd1, 0, 0, 1'b0, 12'h000);
        repeat (300) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_tile = 2'd3; cmd_x = 10'd5; cmd_y = 9'd5; cmd_color = 12'h123;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done("t1", 1024);

        // 2: solid fill clipped at bottom-right corner
        issue(2'd3, 624, 464, 1'b0, 12'h0F0);
        wait_done("t2", 256);

        // 3: wall tile with transparency
        issue(2'd2, 300, 200, 1'b1, 12'hABC);
        wait_done("t3", 924);

        // 4: CPU writes stall the blit for 10 cycles
        issue(2'd0, 100, 50, 1'b0, 12'h000);
        stall_exp = 10;
        repeat (200) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1;
            cpu_vram_we   = 1'b1;
            cpu_vram_addr = 19'(400000 + k * 37);
            cpu_vram_data = 12'(12'hA00 + k);
            @(posedge clk);
        end
        #1;
        cpu_vram_we = 1'b0;
        wait_done("t4", 1024);
        chk("t4_cpu_q", cpu_q.size(), 32'd0);

        // 5: reset during RUN cycle 500 aborts the blit
        issue(2'd1, 200, 100, 1'b0, 12'h000);
        repeat (499) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        blit_q.delete();
        expect_done = 0;
        @(negedge clk);
        chk("t5_we", {31'd0, vram_we}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        blit_wr = 0;
        repeat (1100) @(negedge clk);
        chk("t5_no_writes", blit_wr, 32'd0);
        issue(2'd0, 608, 0, 1'b0, 12'h000);
        wait_done("t5b", 1024);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
